// File: rtl/timer_display_driver.sv
// MM.SS display stage: converts the timer's minute/second bytes to BCD with a
// sequential double-dabble and scans them onto a 4-digit common-anode display.
module timer_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] MSBbinaryin,
  input  logic [7:0] LSBbinaryin,
  input  logic       StopLED,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     msb_in_q, msb_in_d, lsb_in_q, lsb_in_d;
  logic [7:0]     last_msb_q, last_msb_d, last_lsb_q, last_lsb_d;
  logic [7:0]     bin_m_q, bin_m_d, bin_s_q, bin_s_d;
  logic [7:0]     bcd_m_q, bcd_m_d, bcd_s_q, bcd_s_d;
  logic [7:0]     adj_m, adj_s;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]    disp_q, disp_d;
  logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           blank_q, blank_d;
  logic [3:0]     digit;
  logic [6:0]     seg_q, seg_d;
  logic [3:0]     an_q, an_d;
  logic           dp_q, dp_d;

  function automatic logic [7:0] add3(input logic [7:0] b);
    add3[3:0] = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    add3[7:4] = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    msb_in_d    = MSBbinaryin;
    lsb_in_d    = LSBbinaryin;
    last_msb_d  = last_msb_q;
    last_lsb_d  = last_lsb_q;
    bin_m_d     = bin_m_q;
    bin_s_d     = bin_s_q;
    bcd_m_d     = bcd_m_q;
    bcd_s_d     = bcd_s_q;
    bit_cnt_d   = bit_cnt_q;
    disp_d      = disp_q;
    adj_m       = add3(bcd_m_q);
    adj_s       = add3(bcd_s_q);

    case (state_q)
      IDLE: if (msb_in_q != last_msb_q || lsb_in_q != last_lsb_q) state_d = LOAD;
      LOAD: begin
        last_msb_d = msb_in_q;
        last_lsb_d = lsb_in_q;
        bin_m_d    = (msb_in_q > 8'd99) ? 8'd99 : msb_in_q;
        bin_s_d    = (lsb_in_q > 8'd99) ? 8'd99 : lsb_in_q;
        bcd_m_d    = '0;
        bcd_s_d    = '0;
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        bcd_m_d   = {adj_m[6:0], bin_m_q[7]};
        bcd_s_d   = {adj_s[6:0], bin_s_q[7]};
        bin_m_d   = {bin_m_q[6:0], 1'b0};
        bin_s_d   = {bin_s_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = DONE;
      end
      default: begin
        // all four digits land together so no half-converted value is shown
        disp_d  = {bcd_m_q, bcd_s_q};
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q + SW'(1);
    idx_d       = idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    blink_cnt_d = blink_cnt_q + BW'(1);
    blank_d     = blank_q;
    if (!StopLED) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blank_d     = ~blank_q;
    end

    case (idx_q)
      2'd0:    digit = disp_q[3:0];
      2'd1:    digit = disp_q[7:4];
      2'd2:    digit = disp_q[11:8];
      default: digit = disp_q[15:12];
    endcase
    seg_d = seg7(digit);
    an_d  = ~(4'b0001 << idx_q);
    dp_d  = (idx_q != 2'd2);
    if (blank_q) begin
      an_d = 4'b1111;
      dp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      msb_in_q    <= '0;
      lsb_in_q    <= '0;
      last_msb_q  <= '0;
      last_lsb_q  <= '0;
      bin_m_q     <= '0;
      bin_s_q     <= '0;
      bcd_m_q     <= '0;
      bcd_s_q     <= '0;
      bit_cnt_q   <= '0;
      disp_q      <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      seg_q       <= 7'b1111111;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      msb_in_q    <= msb_in_d;
      lsb_in_q    <= lsb_in_d;
      last_msb_q  <= last_msb_d;
      last_lsb_q  <= last_lsb_d;
      bin_m_q     <= bin_m_d;
      bin_s_q     <= bin_s_d;
      bcd_m_q     <= bcd_m_d;
      bcd_s_q     <= bcd_s_d;
      bit_cnt_q   <= bit_cnt_d;
      disp_q      <= disp_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_timer_display_driver.sv
module tb_timer_display_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] MSBbinaryin, LSBbinaryin;
  logic       StopLED;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  int         checks = 0;
  int         errors = 0;

  timer_display_driver #(.SCAN_DIV(4), .BLINK_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n), .MSBbinaryin(MSBbinaryin), .LSBbinaryin(LSBbinaryin),
    .StopLED(StopLED), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] an_tab [4];
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst_n = 1'b0; MSBbinaryin = 8'd0; LSBbinaryin = 8'd0; StopLED = 1'b0;
    #12;
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("FAIL reset_out got %b_%b_%b exp 1111_1111111_1", an, seg, dp);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    tick(1);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("FAIL first_clock got %b_%b_%b exp 1110_1000000_1", an, seg, dp);
    end
    for (int e = 1; e < 12; e++) begin
      tick(1);
      checks++;
      if ({an, seg, dp} !== {an_tab[(e / 4) % 4], 7'b1000000, ((e / 4) % 4) != 2}) begin
        errors++;
        $display("FAIL reset_scan e=%0d got %b_%b_%b exp %b_1000000_%b", e, an, seg, dp,
                 an_tab[(e / 4) % 4], ((e / 4) % 4) != 2);
      end
    end
    checks++;
    if (dut.disp_q !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle_disp got %h exp 0000", dut.disp_q);
    end
  endtask

  task automatic test_convert;
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    logic [3:0] prev;
    bit found;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{7'b0010000, 7'b0010010, 7'b0100100, 7'b1000000};
    tick(2);
    MSBbinaryin = 8'd2; LSBbinaryin = 8'd59;
    tick(11);
    checks++;
    if (dut.disp_q !== 16'h0000) begin
      errors++;
      $display("FAIL conv_early got %h exp 0000", dut.disp_q);
    end
    tick(1);
    checks++;
    if (dut.disp_q !== 16'h0259) begin
      errors++;
      $display("FAIL conv_latency got %h exp 0259", dut.disp_q);
    end
    tick(1);
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL scan_sync got no digit0 start exp within 40 cycles");
    end
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if ({an, seg, dp} !== {an_tab[d], seg_tab[d], d != 2}) begin
          errors++;
          $display("FAIL scan_0259 d=%0d c=%0d got %b_%b_%b exp %b_%b_%b", d, c, an, seg, dp,
                   an_tab[d], seg_tab[d], d != 2);
        end
        tick(1);
      end
    end
  endtask

  task automatic test_clamp;
    tick(2);
    MSBbinaryin = 8'd150; LSBbinaryin = 8'd255;
    tick(12);
    checks++;
    if (dut.disp_q !== 16'h9999) begin
      errors++;
      $display("FAIL clamp got %h exp 9999", dut.disp_q);
    end
  endtask

  task automatic test_mid_change;
    tick(2);
    MSBbinaryin = 8'd1; LSBbinaryin = 8'd30;
    tick(3);
    LSBbinaryin = 8'd29;
    tick(8);
    checks++;
    if (dut.disp_q !== 16'h9999) begin
      errors++;
      $display("FAIL mid_before got %h exp 9999", dut.disp_q);
    end
    tick(1);
    checks++;
    if (dut.disp_q !== 16'h0130) begin
      errors++;
      $display("FAIL mid_first got %h exp 0130", dut.disp_q);
    end
    tick(10);
    checks++;
    if (dut.disp_q !== 16'h0130) begin
      errors++;
      $display("FAIL mid_hold got %h exp 0130", dut.disp_q);
    end
    tick(1);
    checks++;
    if (dut.disp_q !== 16'h0129) begin
      errors++;
      $display("FAIL mid_final got %h exp 0129", dut.disp_q);
    end
  endtask

  task automatic test_reset_mid;
    tick(2);
    MSBbinaryin = 8'd5; LSBbinaryin = 8'd5;
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got %b_%b_%b exp 1111_1111111_1", an, seg, dp);
    end
    checks++;
    if (dut.disp_q !== 16'h0000) begin
      errors++;
      $display("FAIL reset_disp got %h exp 0000", dut.disp_q);
    end
    MSBbinaryin = 8'd0; LSBbinaryin = 8'd0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick(1);
    checks++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("FAIL rerelease got %b_%b_%b exp 1110_1000000_1", an, seg, dp);
    end
    tick(15);
    checks++;
    if (dut.disp_q !== 16'h0000) begin
      errors++;
      $display("FAIL aborted_conv got %h exp 0000", dut.disp_q);
    end
  endtask

  task automatic test_blink;
    StopLED = 1'b1;
    tick(10);
    checks++;
    if ($countones(~an) !== 1) begin
      errors++;
      $display("FAIL blink_pre got %b exp one digit on", an);
    end
    tick(1);
    checks++;
    if ({an, dp} !== {4'b1111, 1'b1}) begin
      errors++;
      $display("FAIL blink_on got %b_%b exp 1111_1", an, dp);
    end
    tick(9);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL blink_hold got %b exp 1111", an);
    end
    tick(1);
    checks++;
    if ($countones(~an) !== 1) begin
      errors++;
      $display("FAIL blink_off got %b exp one digit on", an);
    end
    tick(10);
    checks++;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL blink_on2 got %b exp 1111", an);
    end
    StopLED = 1'b0;
    tick(1);
    checks++;
    if (dut.blank_q !== 1'b0) begin
      errors++;
      $display("FAIL blink_clear got %b exp 0", dut.blank_q);
    end
    tick(1);
    checks++;
    if ($countones(~an) !== 1) begin
      errors++;
      $display("FAIL blink_resume got %b exp one digit on", an);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp;
    MSBbinaryin = 8'd0;
    for (int v = 10; v >= 0; v--) begin
      LSBbinaryin = 8'(v);
      tick(20);
      exp = {8'h00, 4'(v / 10), 4'(v % 10)};
      checks++;
      if (dut.disp_q !== exp) begin
        errors++;
        $display("FAIL countdown v=%0d got %h exp %h", v, dut.disp_q, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_convert;
    test_clamp;
    test_mid_change;
    test_reset_mid;
    test_blink;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_display_driver.md
# timer_display_driver

Downstream display stage for the two-mode timer. Consumes the timer core's two 8-bit binary count outputs (minutes byte, seconds byte) and its stop indication. Converts each byte to two BCD digits with a sequential shift-and-add-3 converter. Drives a time-multiplexed 4-digit, common-anode seven-segment display (MM.SS), blinking the whole display while the stop indication is high.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range is 2 or more.
- BLINK_DIV, 25000000: clock cycles per blink half-period while StopLED is high; legal range is 2 or more.

- clk  in  1  system clock; the block has one clock.
- rst_n  in  1  asynchronous, active-low reset.
- MSBbinaryin  in  8  minutes value from the timer core, unsigned.
- LSBbinaryin  in  8  seconds value from the timer core, unsigned.
- StopLED  in  1  timer expired/stopped indication; high requests blinking.
- seg  out  7  segment drive, active low, bit order {g,f,e,d,c,b,a}.
- an  out  4  digit enables, active low; an[0] is seconds ones, an[3] is minutes tens.
- dp  out  1  decimal point, active low; acts as the MM.SS separator.

## Operation
- Converter FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE → LOAD when either input byte differs from last_msb/last_lsb.
  - LOAD (1 cycle):
    - Latch both inputs into last_msb/last_lsb.
    - Clamp any value above 99 to 99 before conversion.
    - Clear the BCD scratch registers.
  - SHIFT (exactly 8 cycles): double dabble runs on both bytes in parallel. Each cycle, add 3 to every scratch BCD nibble ≥5, then shift left 1.
  - DONE (1 cycle): write all 4 digits atomically to disp_reg {m_tens, m_ones, s_tens, s_ones}, then go to IDLE.
- Input changes during LOAD/SHIFT/DONE are ignored. After returning to IDLE, the compare runs again, so the final input value is always converted. No conversion result is ever partially displayed.
- Scan logic:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At wrap, digit index advances 0→1→2→3→0.
  - Each digit's output is registered as follows:
    - idx 0: an=1110, seconds ones.
    - idx 1: an=1101, seconds tens.
    - idx 2: an=1011, minutes ones, dp=0.
    - idx 3: an=0111, minutes tens.
  - dp=1 on all other digits. No leading-zero blanking.
- Segment code, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD nibble (unreachable) displays 0111111 ("-").
- Blink logic:
  - While StopLED=1, blink_cnt counts 0..BLINK_DIV-1 and toggles blank_ph at wrap.
  - While blank_ph=1, an=1111 and dp=1; scanning and conversion continue underneath.
  - When StopLED=0, blink_cnt is cleared and blank_ph is cleared to 0 on the same cycle.

## Timing
- Reset values (async, immediate):
  - an=1111, seg=1111111, dp=1.
  - FSM=IDLE; last_msb=last_lsb=0; disp_reg=0.
  - scan_cnt=0, idx=0, blink_cnt=0, blank_ph=0.
- First clock after rst_n deasserts: an=1110, seg=1000000 (digit 0 of 00:00).
- Conversion latency:
  - Input change sampled in IDLE at edge N.
  - LOAD occupies N+1, SHIFT N+2..N+9, DONE N+10.
  - disp_reg is valid from edge N+11, and visible on seg at the next registered output update (edge N+12 for the currently enabled digit).
- Minimum conversion period is 11 cycles, including the return to IDLE.
- Each digit is enabled for exactly SCAN_DIV cycles. A full frame is 4×SCAN_DIV cycles.
- Blink half-period is exactly BLINK_DIV cycles. The first blank phase starts BLINK_DIV cycles after StopLED rises.
- Outputs are registered with no combinational path from inputs to outputs.
- Reset mid-conversion aborts the conversion; disp_reg returns to 0.
- A disp_reg update mid-digit takes effect on the next output register update, with no glitch longer than 1 cycle.

## Test plan
- Reset:
  - Assert rst_n=0 mid-scan → an=1111, seg=1111111, dp=1 asynchronously.
  - Release with inputs 0/0 → FSM stays IDLE, digits scan 0,0,0,0.
- Conversion with SCAN_DIV=4:
  - Stimulus: MSBbinaryin=2, LSBbinaryin=59.
  - Expect disp_reg=0x0259 exactly 11 cycles after the sampling edge.
  - Expect scan order an=1110 seg=0010000, an=1101 seg=0010010, an=1011 seg=0100100 dp=0, an=0111 seg=1000000, each 4 cycles.
- Clamp: MSBbinaryin=150, LSBbinaryin=255 → displayed 99:99.
- Mid-conversion change: inputs 1/30, then 1/29 three cycles later → disp_reg shows 0x0130, then 0x0129. Final value 0x0129 is present within 22 cycles of the first change.
- Blink with BLINK_DIV=10:
  - StopLED=1 → an toggles between scanning and 1111 every 10 cycles.
  - StopLED=0 → scanning resumes next cycle with blank_ph=0.
- Back-to-back countdown: seconds input decrements every 20 cycles from 10 to 0 → every value appears in disp_reg in order, none skipped.
